feature_map_writer: RTL and testbench

FEATURE_MAP_WRITER -- requirements
Module: feature_map_writer

---
 rtl/feature_map_writer_pkg.sv | 15 +
 rtl/fm_vec_fifo.sv | 46 ++++
 rtl/feature_map_writer.sv | 142 ++++++++++++++
 tb/tb_feature_map_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_map_writer_pkg.sv
// rtl/feature_map_writer_pkg.sv - shared conv pipeline constants and writer FSM encoding
package feature_map_writer_pkg;

    localparam int BITSIZE    = 18;
    localparam int FRAC_BITS  = 9;
    localparam int NUM_CH     = 16;
    localparam int OUT_SIZE   = 112;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fm_vec_fifo.sv
// rtl/fm_vec_fifo.sv - vector FIFO between conv2d output and the feature-map writer
module fm_vec_fifo #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    // Full is registered occupancy only, so a same-edge pop never frees a slot early.
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/feature_map_writer.sv
// rtl/feature_map_writer.sv - serialises conv2d output vectors into channel-major feature-map memory
module feature_map_writer
    import feature_map_writer_pkg::*;
#(
    parameter int bitsize    = BITSIZE,
    parameter int FRAC_BITS  = feature_map_writer_pkg::FRAC_BITS,
    parameter int NUM_CH     = feature_map_writer_pkg::NUM_CH,
    parameter int OUT_SIZE   = feature_map_writer_pkg::OUT_SIZE,
    parameter int FIFO_DEPTH = feature_map_writer_pkg::FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(NUM_CH * OUT_SIZE * OUT_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hs_valid,
    input  logic [bitsize*NUM_CH-1:0] hs_result,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [bitsize-1:0]        mem_wdata,
    input  logic                      mem_ready,
    output logic                      frame_done,
    output logic                      overflow
);

    localparam int VEC_W = bitsize * NUM_CH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POS_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(OUT_SIZE - 1);
    localparam logic [ADDR_W-1:0] PLANE_A  = ADDR_W'(OUT_SIZE * OUT_SIZE);
    localparam logic [ADDR_W-1:0] ROW_A    = ADDR_W'(OUT_SIZE);

    // Data is passed through as raw fixed-point words; the fraction width is informational.
    logic [31:0] unused_frac_bits;
    assign unused_frac_bits = 32'(FRAC_BITS);

    wr_state_e          state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [POS_W-1:0]   row_q, row_d, col_q, col_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [VEC_W-1:0]   fifo_rdata;
    logic [ADDR_W-1:0]  addr_calc;

    assign in_ready  = !fifo_full;
    assign fifo_push = hs_valid && !fifo_full;

    fm_vec_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (hs_result),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            ch_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            ch_q         <= ch_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        ch_d         = ch_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (hs_valid & fifo_full);
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    vec_d    = fifo_rdata;
                    ch_d     = '0;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    if (ch_q == CH_LAST) begin
                        ch_d = '0;
                        if (col_q == POS_LAST) begin
                            col_d = '0;
                            if (row_q == POS_LAST) begin
                                row_d        = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        // Chain straight into the next queued vector to keep writes gapless.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            vec_d    = fifo_rdata;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign addr_calc  = ADDR_W'(ch_q) * PLANE_A + ADDR_W'(row_q) * ROW_A + ADDR_W'(col_q);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = mem_we ? addr_calc : '0;
    assign mem_wdata  = mem_we ? vec_q[int'(ch_q)*bitsize +: bitsize] : '0;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_feature_map_writer.sv
// tb/tb_feature_map_writer.sv - directed bench for feature_map_writer at OUT_SIZE 112 and 4
module tb_feature_map_writer;

    localparam int BS  = 18;
    localparam int NCH = 16;
    localparam int VW  = BS * NCH;
    localparam int PLANE_A = 12544;
    localparam int PLANE_B = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hs_valid = 1'b0;
    logic [VW-1:0] hs_result = '0;
    logic          mem_ready = 1'b1;

    logic          in_ready_a, mem_we_a, frame_done_a, overflow_a;
    logic [17:0]   mem_addr_a;
    logic [BS-1:0] mem_wdata_a;
    logic          in_ready_b, mem_we_b, frame_done_b, overflow_b;
    logic [7:0]    mem_addr_b;
    logic [BS-1:0] mem_wdata_b;

    feature_map_writer u_dut_a (
        .clk(clk), .rst(rst), .hs_valid(hs_valid), .hs_result(hs_result),
        .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_ready(mem_ready),
        .frame_done(frame_done_a), .overflow(overflow_a)
    );

    feature_map_writer #(.OUT_SIZE(4)) u_dut_b (
        .clk(clk), .rst(rst), .hs_valid(hs_valid), .hs_result(hs_result),
        .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_ready(mem_ready),
        .frame_done(frame_done_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {int addr; int data; int cyc;} wr_t;
    typedef struct {int ch; int addr_a; int addr_b; int data;} vec_t;
    wr_t  act_a[$];
    wr_t  act_b[$];
    int   fd_a[$];
    int   fd_b[$];
    vec_t tbl[NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_vec(input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*BS +: BS] = BS'(base + c);
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted writes are recorded one half-cycle before the edge that takes them.
    logic stall_q = 1'b0;
    int   st_addr = 0;
    int   st_data = 0;
    always @(negedge clk) begin
        if (!rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_hold_addr", mem_addr_b, st_addr);
                check("stall_hold_data", mem_wdata_b, st_data);
            end
            if (mem_we_a && mem_ready) act_a.push_back('{int'(mem_addr_a), int'(mem_wdata_a), cyc});
            if (mem_we_b && mem_ready) act_b.push_back('{int'(mem_addr_b), int'(mem_wdata_b), cyc});
            if (frame_done_a) fd_a.push_back(cyc);
            if (frame_done_b) fd_b.push_back(cyc);
            stall_q <= mem_we_b && !mem_ready;
            st_addr <= int'(mem_addr_b);
            st_data <= int'(mem_wdata_b);
        end
    end

    task automatic push_vec(input logic [VW-1:0] v);
        hs_result = v;
        hs_valid  = 1'b1;
        @(posedge clk); #1;
        hs_valid  = 1'b0;
    endtask

    task automatic wait_b(input int n, input int budget, input string name);
        int k = 0;
        while (act_b.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, act_b.size() >= n, 1);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_we_a"},    mem_we_a, 0);
        check({tag, "_we_b"},    mem_we_b, 0);
        check({tag, "_addr_a"},  mem_addr_a, 0);
        check({tag, "_addr_b"},  mem_addr_b, 0);
        check({tag, "_wdata_a"}, mem_wdata_a, 0);
        check({tag, "_wdata_b"}, mem_wdata_b, 0);
        check({tag, "_fd_b"},    frame_done_b, 0);
        check({tag, "_ovf_a"},   overflow_a, 0);
        check({tag, "_ovf_b"},   overflow_b, 0);
        check({tag, "_rdy_a"},   in_ready_a, 1);
        check({tag, "_rdy_b"},   in_ready_b, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        idle_check("in_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        idle_check("after_reset");

        // single vector, latency and channel-major addressing
        for (int c = 0; c < NCH; c++) tbl[c] = '{c, c*PLANE_A, c*PLANE_B, c+1};
        push_vec(mk_vec(1));
        check("lat_edge_n_we", mem_we_b, 0);
        @(posedge clk); #1;
        check("lat_edge_n1_we", mem_we_b, 1);
        check("lat_first_addr", mem_addr_a, 0);
        check("lat_first_data", mem_wdata_a, 1);
        wait_b(NCH, 100, "single_done");
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("single_addr_a[%0d]", i), act_a[i].addr, tbl[i].addr_a);
            check($sformatf("single_addr_b[%0d]", i), act_b[i].addr, tbl[i].addr_b);
            check($sformatf("single_data[%0d]", i),   act_b[i].data, tbl[i].data);
        end
        repeat (3) @(posedge clk);
        #1;
        check("single_idle_we", mem_we_b, 0);
        check("single_count", act_b.size(), NCH);
        act_a.delete(); act_b.delete();

        // mem_ready toggling every cycle
        mem_ready = 1'b0;
        push_vec(mk_vec(100));
        k = 0;
        while (act_b.size() < NCH && k < 200) begin
            @(posedge clk); #1;
            mem_ready = ~mem_ready;
            k++;
        end
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("toggle_count", act_b.size(), NCH);
        for (int c = 0; c < NCH && c < act_b.size(); c++) begin
            check($sformatf("toggle_addr_a[%0d]", c), act_a[c].addr, c*PLANE_A + 1);
            check($sformatf("toggle_addr_b[%0d]", c), act_b[c].addr, c*PLANE_B + 1);
            check($sformatf("toggle_data[%0d]", c),   act_b[c].data, 100 + c);
        end
        act_a.delete(); act_b.delete();

        // hs_valid held 8 cycles: 5 vectors fit (one popped, four queued), 3 dropped
        for (int v = 0; v < 8; v++) begin
            hs_result = mk_vec(200 + v*16);
            hs_valid  = 1'b1;
            @(posedge clk); #1;
        end
        hs_valid = 1'b0;
        check("burst_in_ready_full", in_ready_b, 0);
        check("burst_overflow_set", overflow_b, 1);
        wait_b(5*NCH, 300, "burst_done");
        repeat (40) @(posedge clk);
        #1;
        check("burst_count", act_b.size(), 5*NCH);
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < NCH; c++) begin
                if (v*NCH + c < act_b.size()) begin
                    check($sformatf("burst_addr_a[%0d,%0d]", v, c), act_a[v*NCH+c].addr, c*PLANE_A + 2 + v);
                    check($sformatf("burst_addr_b[%0d,%0d]", v, c), act_b[v*NCH+c].addr, c*PLANE_B + 2 + v);
                    check($sformatf("burst_data[%0d,%0d]", v, c),   act_b[v*NCH+c].data, 200 + v*16 + c);
                end
            end
        end
        check("burst_overflow_sticky", overflow_a, 1);
        check("burst_in_ready_back", in_ready_b, 1);
        act_a.delete(); act_b.delete();

        // reset while channel 7 of the second vector is on the bus
        push_vec(mk_vec(300));
        push_vec(mk_vec(400));
        push_vec(mk_vec(500));
        k = 0;
        while (act_b.size() < NCH + 7 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_mid_reached", act_b.size(), NCH + 7);
        check("rst_mid_addr_b", mem_addr_b, 7*PLANE_B + 8);
        check("rst_mid_addr_a", mem_addr_a, 7*PLANE_A + 8);
        check("rst_mid_data", mem_wdata_b, 407);
        rst = 1'b0;
        #1;
        idle_check("rst_mid");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        act_a.delete(); act_b.delete();
        repeat (20) @(posedge clk);
        #1;
        check("rst_fifo_discard", act_b.size(), 0);
        push_vec(mk_vec(600));
        wait_b(NCH, 100, "rst_next_done");
        for (int c = 0; c < NCH && c < act_b.size(); c++) begin
            check($sformatf("rst_next_addr_b[%0d]", c), act_b[c].addr, c*PLANE_B);
            check($sformatf("rst_next_data[%0d]", c),   act_b[c].data, 600 + c);
        end
        check("rst_next_overflow", overflow_b, 0);

        // full 4x4 frame plus one vector on the B instance
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        act_a.delete(); act_b.delete(); fd_a.delete(); fd_b.delete();
        for (int v = 0; v < 17; v++) begin
            k = 0;
            while (!in_ready_b && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            push_vec(mk_vec(1000 + v*16));
        end
        wait_b(17*NCH, 600, "frame_done_writes");
        repeat (4) @(posedge clk);
        #1;
        check("frame_count", act_b.size(), 17*NCH);
        for (int p = 0; p < 17; p++) begin
            for (int c = 0; c < NCH; c++) begin
                if (p*NCH + c < act_b.size()) begin
                    check($sformatf("frame_addr_b[%0d,%0d]", p, c), act_b[p*NCH+c].addr, c*PLANE_B + (p % 16));
                    check($sformatf("frame_addr_a[%0d,%0d]", p, c), act_a[p*NCH+c].addr, c*PLANE_A + p);
                    check($sformatf("frame_data[%0d,%0d]", p, c),   act_b[p*NCH+c].data, 1000 + p*16 + c);
                end
            end
        end
        check("frame_done_pulses_b", fd_b.size(), 1);
        check("frame_done_pulses_a", fd_a.size(), 0);
        if (fd_b.size() > 0 && act_b.size() > 256) begin
            check("frame_last_addr", act_b[255].addr, 255);
            check("frame_done_timing", fd_b[0], act_b[255].cyc + 1);
            check("frame_no_gap", act_b[256].cyc, act_b[255].cyc + 1);
            check("frame_next_addr", act_b[256].addr, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
